// File: rtl/bcd_to_binary_iter.sv
// bcd_to_binary_iter
//   Iterative packed-BCD to 32-bit binary converter. It consumes one digit
//   per clock, most-significant digit first, using acc = acc*10 + digit.
//   The start/done handshake is the same as the binary-to-BCD converter's.
//
// Parameters
//   DIGITS      number of BCD digits (1..9), so the result fits in 32 bits
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   start       conversion request, sampled only while busy=0
//   bcd_in      packed BCD input, latched on the accepting edge only
//   binary_out  converted value; holds until the next done
//   done        one-cycle pulse when binary_out/err are updated
//   busy        high while a conversion is in progress
//   err         invalid-digit flag, valid with done
//
// Build option
//   BCD2BIN_DIGIT_CHECK_EN: when defined, nibbles above 9 set err and force
//   binary_out to 0. When undefined, err is tied low and such nibbles are
//   accumulated at their raw value (10..15).
module bcd_to_binary_iter #(
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [31:0]           binary_out,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t state, state_next;

  logic [4*DIGITS-1:0] sr;
  logic [31:0]         acc;
  logic [3:0]          cnt;

  logic [3:0]  d;
  logic [31:0] acc_step;
  logic        last;
  logic        accept;
  logic        finish;

  assign d        = sr[4*DIGITS-1 -: 4];
  // acc*10 written as two shifts plus the new digit
  assign acc_step = (acc << 3) + (acc << 1) + {28'd0, d};
  assign last     = (cnt == 4'(DIGITS - 1));
  assign accept   = (state == IDLE) && start;
  assign finish   = (state == CONV) && last;

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic bad;
  logic bad_now;
  logic err_q;

  // Includes the current digit so the final nibble is checked too.
  assign bad_now = bad | (d > 4'd9);
  assign err     = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr         <= '0;
      acc        <= '0;
      cnt        <= '0;
      binary_out <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      bad        <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        sr   <= bcd_in;
        acc  <= '0;
        cnt  <= '0;
        busy <= 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        bad  <= 1'b0;
`endif
      end else if (state == CONV) begin
        acc <= acc_step;
        sr  <= sr << 4;
        cnt <= cnt + 4'd1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        bad <= bad_now;
`endif
        if (finish) begin
          done <= 1'b1;
          busy <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          binary_out <= bad_now ? '0 : acc_step;
          err_q      <= bad_now;
`else
          binary_out <= acc_step;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_iter.sv
module tb_bcd_to_binary_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] bcd_in;
  logic [31:0] binary_out;
  logic        done;
  logic        busy;
  logic        err;

  logic        start9;
  logic [35:0] bcd9;
  logic [31:0] out9;
  logic        done9;
  logic        busy9;
  logic        err9;

  bcd_to_binary_iter #(.DIGITS(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .binary_out(binary_out), .done(done), .busy(busy), .err(err)
  );

  bcd_to_binary_iter #(.DIGITS(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .start(start9), .bcd_in(bcd9),
    .binary_out(out9), .done(done9), .busy(busy9), .err(err9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Expected result from the digit weights: sum of nibble_i * 10^i.
  function automatic void conv(input logic [35:0] b, input int n,
                               output logic [31:0] v, output logic e);
    longint total = 0;
    longint w = 1;
    logic [35:0] t;
    logic [3:0] nib;
    e = 1'b0;
    t = b;
    for (int i = 0; i < n; i++) begin
      nib = t[3:0];
      t = t >> 4;
      if (nib > 4'd9) e = 1'b1;
      total += longint'(nib) * w;
      w *= 10;
    end
`ifdef BCD2BIN_DIGIT_CHECK_EN
    v = e ? 32'd0 : 32'(total);
`else
    v = 32'(total);
    e = 1'b0;
`endif
  endfunction

  // Transaction-level model of the 6-digit instance.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_err  = 1'b0;
  logic [31:0] m_out  = '0;
  int          m_left = 0;
  logic [31:0] m_pend_v;
  logic        m_pend_e;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_out = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_out  = m_pend_v;
          m_err  = m_pend_e;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_left = 6;
        conv({12'd0, bcd_in}, 6, m_pend_v, m_pend_e);
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        check_en = 1'b0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [31:0] last_out;
  logic        last_err;

  always @(negedge clk) begin
    if (check_en) begin
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("binary_out", binary_out, m_out);
      chk("err", {31'd0, err}, {31'd0, m_err});
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        last_out = binary_out;
        last_err = err;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int bound, input string name);
    int n = 0;
    while (done_cnt < target && n < bound) begin
      step();
      n++;
    end
    if (done_cnt < target) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  int c0;
  int d1cyc;
  int base;

  initial begin
    rst_n = 1'b0; start = 1'b0; bcd_in = '0; start9 = 1'b0; bcd9 = '0;
    step(); step();
    check_en = 1'b1;
    step();
    chk("rst_out", binary_out, 32'd0);
    chk("rst_flags", {29'd0, done, busy, err}, 32'd0);
    rst_n = 1'b1;
    step();

    // 999999, single-cycle start
    base = done_cnt;
    bcd_in = 24'h999999; start = 1'b1; c0 = cyc;
    step();
    start = 1'b0;
    wait_done(base + 1, 20, "s1");
    chk("s1_value", last_out, 32'd999999);
    chk("s1_err", {31'd0, last_err}, 32'd0);
    chk("s1_latency", 32'(done_cyc - c0), 32'd7);
    repeat (3) step();
    chk("s1_single_done", 32'(done_cnt - base), 32'd1);

    // back-to-back: 0 then 123456 with start held
    base = done_cnt;
    bcd_in = 24'h000000; start = 1'b1;
    wait_done(base + 1, 20, "s2a");
    chk("s2_first", last_out, 32'd0);
    d1cyc = done_cyc;
    bcd_in = 24'h123456;
    step();
    start = 1'b0;
    wait_done(base + 2, 20, "s2b");
    chk("s2_second", last_out, 32'd123456);
    chk("s2_spacing", 32'(done_cyc - d1cyc), 32'd7);

    // invalid nibble
    base = done_cnt;
    bcd_in = 24'h12A456; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(base + 1, 20, "s3");
`ifdef BCD2BIN_DIGIT_CHECK_EN
    chk("s3_value", last_out, 32'd0);
    chk("s3_err", {31'd0, last_err}, 32'd1);
`else
    chk("s3_value", last_out, 32'd130456);
    chk("s3_err", {31'd0, last_err}, 32'd0);
`endif

    // start while busy is ignored
    base = done_cnt;
    bcd_in = 24'h000001; start = 1'b1;
    step();
    start = 1'b0;
    step();
    bcd_in = 24'h999999; start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    chk("s4_done_count", 32'(done_cnt - base), 32'd1);
    chk("s4_value", last_out, 32'd1);

    // reset mid-conversion, with start asserted during reset
    base = done_cnt;
    bcd_in = 24'h999999; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst_n = 1'b0; start = 1'b1;
    step();
    rst_n = 1'b1; start = 1'b0;
    chk("s5_out", binary_out, 32'd0);
    chk("s5_flags", {29'd0, done, busy, err}, 32'd0);
    repeat (8) step();
    chk("s5_no_done", 32'(done_cnt - base), 32'd0);
    bcd_in = 24'h000042; start = 1'b1; c0 = cyc;
    step();
    start = 1'b0;
    wait_done(base + 1, 20, "s5");
    chk("s5_value", last_out, 32'd42);
    chk("s5_latency", 32'(done_cyc - c0), 32'd7);

    // 9-digit instance
    bcd9 = 36'h999999999; start9 = 1'b1; c0 = cyc;
    step();
    start9 = 1'b0;
    begin
      int n = 0;
      while (!done9 && n < 30) begin
        step();
        n++;
      end
      chk("d9_done_seen", {31'd0, done9}, 32'd1);
      chk("d9_value", out9, 32'd999999999);
      chk("d9_err", {31'd0, err9}, 32'd0);
      chk("d9_latency", 32'(cyc - c0), 32'd10);
    end
    step();
    chk("d9_done_pulse", {31'd0, done9}, 32'd0);
    chk("d9_hold", out9, 32'h3B9AC9FF);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
